repvgg_acc_core: RTL and testbench
==================================

// Module: repvgg_acc_core
// PURPOSE
// - Memory-mapped RepVGG post-processing accelerator: applies fused BN+ReLU to int8 feature maps already in memory.
// - A CPU programs it over an ICB slave port; it streams words via its own ICB master port (DMA): read SRC, compute, write DST.
// - Sits beside the CPU on the SoC ICB fabric, typically at 0x1004_2000.
// PARAMETERS
// BASE_ADDR  32'h1004_2000  slave window base; decode is icb_cmd_addr[31:8]==BASE_ADDR[31:8]
// LEN_W      16             width of LEN/COUNT registers (max words per job = 2^LEN_W-1)
// PORTS
// clk                in   1   single clock, all logic rising-edge
// rst                in   1   asynchronous, active-high reset
// icb_cmd_valid      in   1   slave cmd valid
// icb_cmd_ready      out  1   slave cmd ready
// icb_cmd_read       in   1   1=read, 0=write
// icb_cmd_addr       in   32  byte address; offset = addr[7:0]
// icb_cmd_wdata      in   32  write data
// icb_cmd_wmask      in   4   byte enables for writes
// icb_rsp_valid      out  1   slave response valid
// icb_rsp_ready      in   1   slave response accepted
// icb_rsp_rdata      out  32  read data (0 on writes/errors)
// icb_rsp_err        out  1   unmapped offset, or config write while BUSY
// acc_icb_cmd_valid  out  1   master cmd valid
// acc_icb_cmd_ready  in   1   master cmd accepted
// acc_icb_cmd_addr   out  32  word-aligned address
// acc_icb_cmd_read   out  1   1=read SRC, 0=write DST
// acc_icb_cmd_wdata  out  32  result word
// acc_icb_cmd_wmask  out  4   4'hF on writes, 4'h0 on reads
// acc_icb_rsp_valid  in   1   master rsp valid
// acc_icb_rsp_ready  out  1   tied 1
// acc_icb_rsp_err    in   1   bus error -> job abort
// acc_icb_rsp_rdata  in   32  read data
// BEHAVIOUR
// - Regs: 0x00 CTRL (W: bit0 START, self-clearing pulse; reads 0). 0x04 STATUS (RO BUSY[0]; W1C DONE[1], ERR[2]).
//   0x08 SRC, 0x0C DST (addr[1:0] forced 0). 0x10 LEN (words). 0x14 BN: [7:0] scale s8, [11:8] shift u4, [31:16] bias s16.
//   0x18 COUNT (RO, words written this job). Other offsets -> rsp_err=1, rdata=0, no state change.
// - Writes honour wmask per byte. Writes to 0x08..0x14 while BUSY: ignored, rsp_err=1.
// - Slave: cmd_ready = !rsp_pending; cmd accepted on valid&ready; rsp_valid asserted next cycle, held until rsp_ready.
//   One outstanding slave transaction; back-to-back throughput 1 per 2 cycles if rsp_ready held 1.
// - Reset: all regs 0, FSM IDLE, icb_rsp_valid=0, acc_icb_cmd_valid=0, addr/wdata/wmask=0, icb_cmd_ready=1, acc_icb_rsp_ready=1.
// - START while IDLE: COUNT<=0, DONE<=0, ERR<=0, BUSY<=1; LEN==0 -> DONE=1, BUSY=0 next cycle, no bus traffic.
//   START while BUSY ignored (no error).
// - FSM IDLE->RD_CMD->RD_RSP->WR_CMD->WR_RSP->(COUNT<LEN ? RD_CMD : IDLE+DONE). One master transaction outstanding.
//   RD_CMD: valid=1, read=1, addr=SRC+4*COUNT; hold stable until ready. RD_RSP: latch rdata on rsp_valid.
//   WR_CMD: read=0, addr=DST+4*COUNT, wdata=result. WR_RSP: on rsp_valid COUNT++.
// - acc_icb_rsp_err=1 on any rsp: abort to IDLE, ERR=1, DONE=1, BUSY=0; COUNT keeps words completed.
// - Lane math (4 independent byte lanes, lane i = bits 8i+7:8i): x s8; p = x*scale + bias (signed, 18 bit, no overflow);
//   y = p >>> shift (arithmetic); out = y<0 ? 0 : y>127 ? 127 : y[7:0]. Result registered in RD_RSP->WR_CMD transition.
// - Async reset mid-job: everything returns to reset state immediately; in-flight bus handshake abandoned.
// STRUCTURE
// - Package repvgg_acc_pkg: register offset localparams, STATUS bit indices, FSM state enum (IDLE,RD_CMD,RD_RSP,WR_CMD,WR_RSP).
// - Sub-module repvgg_acc_bn_relu: combinational single-lane BN+ReLU, instantiated 4x.
// - Top: slave reg file/decode + DMA FSM.
// TESTING
// - Reg R/W: write SRC=0x2000_0003 -> read 0x2000_0000; write wmask=4'b0001 0xFF to BN -> only [7:0]=0xFF; read 0x40 -> err=1, rdata=0.
// - Job: SRC=0x100,DST=0x200,LEN=2,BN scale=2,shift=1,bias=0, mem[0x100]=0x7F_FE_03_80 -> DST word 0x7F_00_03_00, STATUS=0x2, COUNT=2.
// - Bias/clamp: scale=1,shift=0,bias=-5, word 0x04_0A_05_7F -> 0x00_05_00_7A; bias=+200 -> all lanes 0x7F.
// - Backpressure: random acc_icb_cmd_ready/rsp_valid delays 0-7 cycles -> cmd fields stable while valid&!ready, same results.
// - Error: rsp_err on 2nd read of LEN=4 -> STATUS=0x6, COUNT=1, no further master cmds; W1C 0x6 clears to 0.
// - Corner: LEN=0 START -> DONE next cycle, zero master cmds; START while BUSY ignored; config write while BUSY -> err=1.

Source files
------------

// File: rtl/repvgg_acc_pkg.sv
// Shared definitions for the RepVGG BN+ReLU accelerator: register map, STATUS bits, DMA states.
package repvgg_acc_pkg;

    localparam logic [7:0] OFF_CTRL   = 8'h00;
    localparam logic [7:0] OFF_STATUS = 8'h04;
    localparam logic [7:0] OFF_SRC    = 8'h08;
    localparam logic [7:0] OFF_DST    = 8'h0C;
    localparam logic [7:0] OFF_LEN    = 8'h10;
    localparam logic [7:0] OFF_BN     = 8'h14;
    localparam logic [7:0] OFF_COUNT  = 8'h18;

    localparam int ST_BUSY = 0;
    localparam int ST_DONE = 1;
    localparam int ST_ERR  = 2;

    typedef enum logic [2:0] {
        IDLE,
        RD_CMD,
        RD_RSP,
        WR_CMD,
        WR_RSP
    } acc_state_t;

    function automatic logic [31:0] apply_wmask(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  wmask);
        logic [31:0] merged;
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = wmask[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/repvgg_acc_bn_relu.sv
// Single int8 lane of fused BN+ReLU: clamp((x*scale + bias) >>> shift) to 0..127.
module repvgg_acc_bn_relu (
    input  logic [7:0]  x,
    input  logic [7:0]  scale,
    input  logic [3:0]  shift,
    input  logic [15:0] bias,
    output logic [7:0]  y
);

    logic signed [17:0] x_s;
    logic signed [17:0] scale_s;
    logic signed [17:0] bias_s;
    logic signed [17:0] p;
    logic signed [17:0] q;

    assign x_s     = {{10{x[7]}}, x};
    assign scale_s = {{10{scale[7]}}, scale};
    assign bias_s  = {{2{bias[15]}}, bias};
    // 8x8 product plus 16-bit bias cannot exceed 18 signed bits
    assign p       = x_s * scale_s + bias_s;
    assign q       = p >>> shift;

    assign y = q[17] ? 8'd0 : (q > 18'sd127) ? 8'd127 : q[7:0];

endmodule

// File: rtl/repvgg_acc_core.sv
// RepVGG post-processing accelerator: ICB slave register file plus a DMA FSM that
// reads SRC words, applies per-lane BN+ReLU and writes them to DST.
//
// state  | meaning
// IDLE   | no job; also retires a zero-length job one cycle after START
// RD_CMD | read command to SRC+4*COUNT presented
// RD_RSP | waiting for read data
// WR_CMD | write of processed word to DST+4*COUNT presented
// WR_RSP | waiting for write ack, then next word or finish
module repvgg_acc_core
    import repvgg_acc_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h1004_2000,
    parameter int unsigned LEN_W     = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        icb_cmd_valid,
    output logic        icb_cmd_ready,
    input  logic        icb_cmd_read,
    input  logic [31:0] icb_cmd_addr,
    input  logic [31:0] icb_cmd_wdata,
    input  logic [3:0]  icb_cmd_wmask,
    output logic        icb_rsp_valid,
    input  logic        icb_rsp_ready,
    output logic [31:0] icb_rsp_rdata,
    output logic        icb_rsp_err,
    output logic        acc_icb_cmd_valid,
    input  logic        acc_icb_cmd_ready,
    output logic [31:0] acc_icb_cmd_addr,
    output logic        acc_icb_cmd_read,
    output logic [31:0] acc_icb_cmd_wdata,
    output logic [3:0]  acc_icb_cmd_wmask,
    input  logic        acc_icb_rsp_valid,
    output logic        acc_icb_rsp_ready,
    input  logic        acc_icb_rsp_err,
    input  logic [31:0] acc_icb_rsp_rdata
);

    acc_state_t       state_q, state_d;
    logic [31:0]      src_q, dst_q, bn_q, result_q, result_d;
    logic [LEN_W-1:0] len_q, count_q, count_inc;
    logic             busy_q, done_q, err_q;
    logic             rsp_valid_q, rsp_err_q;
    logic [31:0]      rsp_rdata_q;
    logic [7:0]       off;
    logic [31:0]      rd_val, len_ext, cnt_ext;
    logic             cmd_fire, win_hit, cfg_off, dec_err, slv_err, wr_ok, start_ok;
    logic             job_fin, job_abort, cnt_inc, res_load;

    assign off               = icb_cmd_addr[7:0];
    assign win_hit           = icb_cmd_addr[31:8] == BASE_ADDR[31:8];
    assign icb_cmd_ready     = !rsp_valid_q;
    assign cmd_fire          = icb_cmd_valid && icb_cmd_ready;
    assign icb_rsp_valid     = rsp_valid_q;
    assign icb_rsp_err       = rsp_err_q;
    assign icb_rsp_rdata     = rsp_rdata_q;
    assign acc_icb_rsp_ready = 1'b1;
    assign len_ext           = 32'(len_q);
    assign cnt_ext           = 32'(count_q);
    assign count_inc         = count_q + LEN_W'(1);

    always_comb begin
        rd_val  = '0;
        dec_err = 1'b0;
        cfg_off = 1'b0;
        if (!win_hit) begin
            dec_err = 1'b1;
        end else begin
            case (off)
                OFF_CTRL:   rd_val = '0;
                OFF_STATUS: begin
                    rd_val[ST_BUSY] = busy_q;
                    rd_val[ST_DONE] = done_q;
                    rd_val[ST_ERR]  = err_q;
                end
                OFF_SRC:    begin rd_val = src_q;   cfg_off = 1'b1; end
                OFF_DST:    begin rd_val = dst_q;   cfg_off = 1'b1; end
                OFF_LEN:    begin rd_val = len_ext; cfg_off = 1'b1; end
                OFF_BN:     begin rd_val = bn_q;    cfg_off = 1'b1; end
                OFF_COUNT:  rd_val = cnt_ext;
                default:    dec_err = 1'b1;
            endcase
        end
        slv_err  = dec_err || (!icb_cmd_read && cfg_off && busy_q);
        wr_ok    = cmd_fire && !icb_cmd_read && !slv_err;
        start_ok = wr_ok && (off == OFF_CTRL) && icb_cmd_wmask[0] && icb_cmd_wdata[0] && !busy_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else if (cmd_fire) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= slv_err;
            rsp_rdata_q <= (icb_cmd_read && !slv_err) ? rd_val : '0;
        end else if (icb_rsp_ready) begin
            rsp_valid_q <= 1'b0;
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_lane
        repvgg_acc_bn_relu u_lane (
            .x     (acc_icb_rsp_rdata[8*i +: 8]),
            .scale (bn_q[7:0]),
            .shift (bn_q[11:8]),
            .bias  (bn_q[31:16]),
            .y     (result_d[8*i +: 8])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        acc_icb_cmd_valid = 1'b0;
        acc_icb_cmd_read  = 1'b0;
        acc_icb_cmd_addr  = '0;
        acc_icb_cmd_wdata = '0;
        acc_icb_cmd_wmask = '0;
        job_fin           = 1'b0;
        job_abort         = 1'b0;
        cnt_inc           = 1'b0;
        res_load          = 1'b0;
        case (state_q)
            IDLE: begin
                if (busy_q) begin
                    job_fin = 1'b1;
                end else if (start_ok && len_q != '0) begin
                    state_d = RD_CMD;
                end
            end
            RD_CMD: begin
                acc_icb_cmd_valid = 1'b1;
                acc_icb_cmd_read  = 1'b1;
                acc_icb_cmd_addr  = src_q + (cnt_ext << 2);
                if (acc_icb_cmd_ready) state_d = RD_RSP;
            end
            RD_RSP: begin
                if (acc_icb_rsp_valid) begin
                    if (acc_icb_rsp_err) begin
                        job_abort = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        res_load = 1'b1;
                        state_d  = WR_CMD;
                    end
                end
            end
            WR_CMD: begin
                acc_icb_cmd_valid = 1'b1;
                acc_icb_cmd_addr  = dst_q + (cnt_ext << 2);
                acc_icb_cmd_wdata = result_q;
                acc_icb_cmd_wmask = 4'hF;
                if (acc_icb_cmd_ready) state_d = WR_RSP;
            end
            WR_RSP: begin
                if (acc_icb_rsp_valid) begin
                    if (acc_icb_rsp_err) begin
                        job_abort = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        cnt_inc = 1'b1;
                        if (count_inc < len_q) begin
                            state_d = RD_CMD;
                        end else begin
                            job_fin = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_q    <= '0;
            dst_q    <= '0;
            len_q    <= '0;
            bn_q     <= '0;
            count_q  <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            if (wr_ok) begin
                case (off)
                    OFF_STATUS: begin
                        if (icb_cmd_wmask[0] && icb_cmd_wdata[ST_DONE]) done_q <= 1'b0;
                        if (icb_cmd_wmask[0] && icb_cmd_wdata[ST_ERR])  err_q  <= 1'b0;
                    end
                    OFF_SRC: src_q <= apply_wmask(src_q, icb_cmd_wdata, icb_cmd_wmask) & 32'hFFFF_FFFC;
                    OFF_DST: dst_q <= apply_wmask(dst_q, icb_cmd_wdata, icb_cmd_wmask) & 32'hFFFF_FFFC;
                    OFF_LEN: len_q <= LEN_W'(apply_wmask(len_ext, icb_cmd_wdata, icb_cmd_wmask));
                    OFF_BN:  bn_q  <= apply_wmask(bn_q, icb_cmd_wdata, icb_cmd_wmask);
                    default: ;
                endcase
            end
            if (start_ok) begin
                busy_q  <= 1'b1;
                done_q  <= 1'b0;
                err_q   <= 1'b0;
                count_q <= '0;
            end
            if (res_load) result_q <= result_d;
            if (cnt_inc)  count_q  <= count_inc;
            if (job_fin) begin
                busy_q <= 1'b0;
                done_q <= 1'b1;
            end
            if (job_abort) begin
                busy_q <= 1'b0;
                done_q <= 1'b1;
                err_q  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_repvgg_acc_core.sv
// Directed bench for repvgg_acc_core: register access, BN+ReLU jobs, backpressure, abort and corners.
module tb_repvgg_acc_core;

    localparam logic [31:0] BASE = 32'h1004_2000;

    logic        clk, rst;
    logic        icb_cmd_valid, icb_cmd_ready, icb_cmd_read;
    logic [31:0] icb_cmd_addr, icb_cmd_wdata;
    logic [3:0]  icb_cmd_wmask;
    logic        icb_rsp_valid, icb_rsp_ready, icb_rsp_err;
    logic [31:0] icb_rsp_rdata;
    logic        acc_icb_cmd_valid, acc_icb_cmd_ready, acc_icb_cmd_read;
    logic [31:0] acc_icb_cmd_addr, acc_icb_cmd_wdata;
    logic [3:0]  acc_icb_cmd_wmask;
    logic        acc_icb_rsp_valid, acc_icb_rsp_ready, acc_icb_rsp_err;
    logic [31:0] acc_icb_rsp_rdata;

    repvgg_acc_core #(.BASE_ADDR(BASE), .LEN_W(16)) dut (
        .clk               (clk),
        .rst               (rst),
        .icb_cmd_valid     (icb_cmd_valid),
        .icb_cmd_ready     (icb_cmd_ready),
        .icb_cmd_read      (icb_cmd_read),
        .icb_cmd_addr      (icb_cmd_addr),
        .icb_cmd_wdata     (icb_cmd_wdata),
        .icb_cmd_wmask     (icb_cmd_wmask),
        .icb_rsp_valid     (icb_rsp_valid),
        .icb_rsp_ready     (icb_rsp_ready),
        .icb_rsp_rdata     (icb_rsp_rdata),
        .icb_rsp_err       (icb_rsp_err),
        .acc_icb_cmd_valid (acc_icb_cmd_valid),
        .acc_icb_cmd_ready (acc_icb_cmd_ready),
        .acc_icb_cmd_addr  (acc_icb_cmd_addr),
        .acc_icb_cmd_read  (acc_icb_cmd_read),
        .acc_icb_cmd_wdata (acc_icb_cmd_wdata),
        .acc_icb_cmd_wmask (acc_icb_cmd_wmask),
        .acc_icb_rsp_valid (acc_icb_rsp_valid),
        .acc_icb_rsp_ready (acc_icb_rsp_ready),
        .acc_icb_rsp_err   (acc_icb_rsp_err),
        .acc_icb_rsp_rdata (acc_icb_rsp_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          nvec = 0;
    int          nfail = 0;
    bit          bp = 1'b0;
    bit          stab_on = 1'b1;
    int          stab_errs = 0;
    int          cmd_cnt = 0;
    int          rd_num = 0;
    int          err_rd = 0;
    logic [31:0] mem [0:1023];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic timeout(input string tag);
        nvec++;
        nfail++;
        $display("FAIL %s: wait bound expired", tag);
    endtask

    // Memory-side responder with optional random ready/response delays
    initial begin : responder
        logic [31:0] c_addr, c_wdata;
        logic        c_read, e;
        logic [3:0]  c_mask;
        int          d;
        acc_icb_cmd_ready = 1'b0;
        acc_icb_rsp_valid = 1'b0;
        acc_icb_rsp_err   = 1'b0;
        acc_icb_rsp_rdata = '0;
        forever begin
            @(negedge clk);
            if (!rst && acc_icb_cmd_valid) begin
                c_addr  = acc_icb_cmd_addr;
                c_wdata = acc_icb_cmd_wdata;
                c_read  = acc_icb_cmd_read;
                c_mask  = acc_icb_cmd_wmask;
                if (c_mask !== (c_read ? 4'h0 : 4'hF)) stab_errs++;
                d = bp ? int'($urandom_range(0, 7)) : 0;
                for (int k = 0; k < d; k++) begin
                    @(negedge clk);
                    if (stab_on && (acc_icb_cmd_valid !== 1'b1 || acc_icb_cmd_addr !== c_addr ||
                        acc_icb_cmd_read !== c_read || acc_icb_cmd_wdata !== c_wdata ||
                        acc_icb_cmd_wmask !== c_mask)) stab_errs++;
                end
                acc_icb_cmd_ready = 1'b1;
                @(negedge clk);
                acc_icb_cmd_ready = 1'b0;
                cmd_cnt++;
                e = 1'b0;
                if (c_read) begin
                    rd_num++;
                    e = (rd_num == err_rd);
                    acc_icb_rsp_rdata = mem[c_addr[11:2]];
                end else begin
                    mem[c_addr[11:2]] = c_wdata;
                end
                d = bp ? int'($urandom_range(0, 7)) : 0;
                repeat (d) @(negedge clk);
                acc_icb_rsp_valid = 1'b1;
                acc_icb_rsp_err   = e;
                @(negedge clk);
                acc_icb_rsp_valid = 1'b0;
                acc_icb_rsp_err   = 1'b0;
            end
        end
    end

    task automatic xfer(input logic rd, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] m, output logic [31:0] rdat, output logic e);
        int n;
        @(negedge clk);
        icb_cmd_valid = 1'b1;
        icb_cmd_read  = rd;
        icb_cmd_addr  = a;
        icb_cmd_wdata = wd;
        icb_cmd_wmask = m;
        n = 0;
        while (!icb_cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) timeout("slv_cmd_ready");
        @(posedge clk);
        #1;
        icb_cmd_valid = 1'b0;
        n = 0;
        while (!icb_rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) timeout("slv_rsp_valid");
        rdat = icb_rsp_rdata;
        e    = icb_rsp_err;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] o, input logic [31:0] wd, input logic [3:0] m, output logic e);
        logic [31:0] dummy;
        xfer(1'b0, BASE + 32'(o), wd, m, dummy, e);
    endtask

    task automatic rd(input logic [7:0] o, output logic [31:0] d, output logic e);
        xfer(1'b1, BASE + 32'(o), '0, 4'h0, d, e);
    endtask

    task automatic wait_idle();
        logic [31:0] s;
        logic        e;
        int          n;
        n = 0;
        do begin
            rd(8'h04, s, e);
            n++;
        end while (s[0] && n < 2000);
        if (s[0]) timeout("job_busy");
    endtask

    task automatic run_job(input logic [31:0] src, input logic [31:0] dst, input logic [31:0] len);
        logic e;
        wr(8'h08, src, 4'hF, e);
        wr(8'h0C, dst, 4'hF, e);
        wr(8'h10, len, 4'hF, e);
        wr(8'h00, 32'h1, 4'hF, e);
        wait_idle();
    endtask

    task automatic job1_checks(input string tag, input int c0);
        logic [31:0] d;
        logic        e;
        chk({tag, "_dst0"}, mem[32'h200 >> 2], 32'h7F00_0300);
        chk({tag, "_dst1"}, mem[32'h204 >> 2], 32'h0100_4000);
        rd(8'h04, d, e);
        chk({tag, "_status"}, d, 32'h2);
        rd(8'h18, d, e);
        chk({tag, "_count"}, d, 32'h2);
        chk({tag, "_cmds"}, 32'(cmd_cnt - c0), 32'd4);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [31:0] d;
        logic        e;
        int          c0;

        for (int i = 0; i < 1024; i++) mem[i] = '0;
        rst           = 1'b1;
        icb_cmd_valid = 1'b0;
        icb_cmd_read  = 1'b0;
        icb_cmd_addr  = '0;
        icb_cmd_wdata = '0;
        icb_cmd_wmask = '0;
        icb_rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", 32'(icb_cmd_ready), 32'h1);
        chk("rst_rsp_valid", 32'(icb_rsp_valid), 32'h0);
        chk("rst_acc_valid", 32'(acc_icb_cmd_valid), 32'h0);
        chk("rst_acc_addr", acc_icb_cmd_addr, 32'h0);
        chk("rst_acc_wdata", acc_icb_cmd_wdata, 32'h0);
        chk("rst_acc_wmask", 32'(acc_icb_cmd_wmask), 32'h0);
        chk("rst_acc_rsp_ready", 32'(acc_icb_rsp_ready), 32'h1);
        @(negedge clk);
        rst = 1'b0;

        rd(8'h04, d, e);
        chk("rst_status", d, 32'h0);
        rd(8'h08, d, e);
        chk("rst_src", d, 32'h0);

        // Register access
        wr(8'h08, 32'h2000_0003, 4'hF, e);
        chk("src_wr_err", 32'(e), 32'h0);
        rd(8'h08, d, e);
        chk("src_align", d, 32'h2000_0000);
        wr(8'h14, 32'hFFFF_FFFF, 4'b0001, e);
        rd(8'h14, d, e);
        chk("bn_mask_lo", d, 32'h0000_00FF);
        wr(8'h14, 32'h1234_5678, 4'b1100, e);
        rd(8'h14, d, e);
        chk("bn_mask_hi", d, 32'h1234_00FF);
        wr(8'h10, 32'hABCD_0005, 4'hF, e);
        rd(8'h10, d, e);
        chk("len_width", d, 32'h0000_0005);
        rd(8'h00, d, e);
        chk("ctrl_reads0", d, 32'h0);
        rd(8'h40, d, e);
        chk("unmapped_rd_err", 32'(e), 32'h1);
        chk("unmapped_rd_data", d, 32'h0);
        wr(8'h40, 32'hFFFF_FFFF, 4'hF, e);
        chk("unmapped_wr_err", 32'(e), 32'h1);
        xfer(1'b1, 32'h1004_3008, '0, 4'h0, d, e);
        chk("window_miss_err", 32'(e), 32'h1);

        // Job: scale=2 shift=1 bias=0
        wr(8'h14, 32'h0000_0102, 4'hF, e);
        mem[32'h100 >> 2] = 32'h7FFE_0380;
        mem[32'h104 >> 2] = 32'h01FF_40C0;
        c0 = cmd_cnt;
        run_job(32'h100, 32'h200, 32'd2);
        job1_checks("job1", c0);

        // Same job under random backpressure
        mem[32'h200 >> 2] = 32'hDEAD_BEEF;
        mem[32'h204 >> 2] = 32'hDEAD_BEEF;
        bp = 1'b1;
        c0 = cmd_cnt;
        run_job(32'h100, 32'h200, 32'd2);
        job1_checks("job1_bp", c0);

        // Bias and clamp
        mem[32'h300 >> 2] = 32'h040A_057F;
        wr(8'h14, 32'hFFFB_0001, 4'hF, e);
        run_job(32'h300, 32'h380, 32'd1);
        chk("bias_neg5", mem[32'h380 >> 2], 32'h0005_007A);
        wr(8'h14, 32'h00C8_0001, 4'hF, e);
        run_job(32'h300, 32'h380, 32'd1);
        chk("bias_200_clamp", mem[32'h380 >> 2], 32'h7F7F_7F7F);
        mem[32'h300 >> 2] = 32'h10F0_0005;
        wr(8'h14, 32'h000A_02FD, 4'hF, e);
        run_job(32'h300, 32'h380, 32'd1);
        chk("neg_scale_shift2", mem[32'h380 >> 2], 32'h000E_0200);

        // Bus error on the second read aborts the job
        wr(8'h14, 32'h0000_0102, 4'hF, e);
        rd_num = 0;
        err_rd = 2;
        c0 = cmd_cnt;
        run_job(32'h100, 32'h200, 32'd4);
        repeat (20) @(posedge clk);
        #1;
        err_rd = 0;
        rd(8'h04, d, e);
        chk("abort_status", d, 32'h6);
        rd(8'h18, d, e);
        chk("abort_count", d, 32'h1);
        chk("abort_cmds", 32'(cmd_cnt - c0), 32'd3);
        wr(8'h04, 32'h6, 4'hF, e);
        rd(8'h04, d, e);
        chk("w1c_status", d, 32'h0);

        // Zero-length job
        c0 = cmd_cnt;
        wr(8'h10, 32'h0, 4'hF, e);
        wr(8'h00, 32'h1, 4'hF, e);
        rd(8'h04, d, e);
        chk("len0_status", d, 32'h2);
        repeat (10) @(posedge clk);
        #1;
        chk("len0_cmds", 32'(cmd_cnt - c0), 32'd0);

        // Writes while BUSY
        wr(8'h08, 32'h100, 4'hF, e);
        wr(8'h0C, 32'h200, 4'hF, e);
        wr(8'h10, 32'h8, 4'hF, e);
        c0 = cmd_cnt;
        wr(8'h00, 32'h1, 4'hF, e);
        wr(8'h08, 32'h500, 4'hF, e);
        chk("busy_cfg_err", 32'(e), 32'h1);
        wr(8'h00, 32'h1, 4'hF, e);
        chk("busy_start_noerr", 32'(e), 32'h0);
        rd(8'h04, d, e);
        chk("busy_status", d, 32'h1);
        wait_idle();
        rd(8'h08, d, e);
        chk("busy_src_kept", d, 32'h100);
        rd(8'h18, d, e);
        chk("busy_count", d, 32'h8);
        chk("busy_cmds", 32'(cmd_cnt - c0), 32'd16);

        // Asynchronous reset mid-job
        stab_on = 1'b0;
        wr(8'h00, 32'h1, 4'hF, e);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_acc_valid", 32'(acc_icb_cmd_valid), 32'h0);
        chk("mid_rst_acc_addr", acc_icb_cmd_addr, 32'h0);
        chk("mid_rst_cmd_ready", 32'(icb_cmd_ready), 32'h1);
        @(negedge clk);
        rst = 1'b0;
        rd(8'h04, d, e);
        chk("mid_rst_status", d, 32'h0);
        rd(8'h08, d, e);
        chk("mid_rst_src", d, 32'h0);

        chk("cmd_stable", 32'(stab_errs), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
